// File: rtl/serial_out_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_out_scheduler_if
//  Description : Requester words/requests, grants and serial line for the
//                two-requester serial output scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_out_scheduler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_0;
    logic [DATA_W-1:0] data_1;
    logic              req_0;
    logic              req_1;
    logic              gnt_0;
    logic              gnt_1;
    logic              serial_out;
    logic              serial_valid;
    logic              owner;
    logic              busy;

    // Producer side: presents words and requests, observes grants and the line.
    modport master (
        output data_0, data_1, req_0, req_1,
        input  gnt_0, gnt_1, serial_out, serial_valid, owner, busy
    );

    // Scheduler side.
    modport slave (
        input  data_0, data_1, req_0, req_1,
        output gnt_0, gnt_1, serial_out, serial_valid, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_out_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : serial_out_scheduler
//  Description : Round-robin two-requester scheduler that serialises the
//                granted word MSB-first, then idles GAP_CYCLES cycles.
//                Define SERIAL_SCHED_PARITY_EN to append an even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_out_scheduler #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    serial_out_scheduler_if.slave bus
);

`ifdef SERIAL_SCHED_PARITY_EN
    localparam int c_FRAME_LEN = DATA_W + 1;
`else
    localparam int c_FRAME_LEN = DATA_W;
`endif
    localparam int c_CNT_W = $clog2(DATA_W + 2);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_FRAME_LEN - 1);
    localparam logic [3:0]         c_GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]         r_state,        w_state_nxt;
    // Holds the bits still to be sent after the one currently on serial_out.
    logic [DATA_W-1:0]  r_shift,        w_shift_nxt;
    logic [c_CNT_W-1:0] r_bit_cnt,      w_bit_cnt_nxt;
    logic [3:0]         r_gap_cnt,      w_gap_cnt_nxt;
    logic               r_last_grant,   w_last_grant_nxt;
    logic               r_gnt_0,        w_gnt_0_nxt;
    logic               r_gnt_1,        w_gnt_1_nxt;
    logic               r_serial_out,   w_serial_out_nxt;
    logic               r_serial_valid, w_serial_valid_nxt;
    logic               r_owner,        w_owner_nxt;
    logic               r_busy,         w_busy_nxt;
`ifdef SERIAL_SCHED_PARITY_EN
    logic               r_parity,       w_parity_nxt;
    localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(DATA_W - 1);
`endif

    logic              w_pick_0;
    logic              w_pick_1;
    logic [DATA_W-1:0] w_sel_data;

    // Contention goes to the requester that was not granted last.
    assign w_pick_0   = bus.req_0 & (~bus.req_1 | r_last_grant);
    assign w_pick_1   = bus.req_1 & ~w_pick_0;
    assign w_sel_data = w_pick_0 ? bus.data_0 : bus.data_1;

    always_comb begin
        w_state_nxt        = r_state;
        w_shift_nxt        = r_shift;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_gap_cnt_nxt      = r_gap_cnt;
        w_last_grant_nxt   = r_last_grant;
        w_gnt_0_nxt        = 1'b0;
        w_gnt_1_nxt        = 1'b0;
        w_serial_out_nxt   = 1'b0;
        w_serial_valid_nxt = 1'b0;
        w_owner_nxt        = r_owner;
        w_busy_nxt         = r_busy;
`ifdef SERIAL_SCHED_PARITY_EN
        w_parity_nxt       = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pick_0 || w_pick_1) begin
                    w_state_nxt        = S_SHIFT;
                    w_gnt_0_nxt        = w_pick_0;
                    w_gnt_1_nxt        = w_pick_1;
                    w_owner_nxt        = w_pick_1;
                    w_last_grant_nxt   = w_pick_1;
                    w_shift_nxt        = {w_sel_data[DATA_W-2:0], 1'b0};
                    w_serial_out_nxt   = w_sel_data[DATA_W-1];
                    w_serial_valid_nxt = 1'b1;
                    w_bit_cnt_nxt      = '0;
                    w_busy_nxt         = 1'b1;
`ifdef SERIAL_SCHED_PARITY_EN
                    w_parity_nxt       = ^w_sel_data;
`endif
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == c_LAST_BIT) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = 4'd0;
                    end
                end else begin
                    w_bit_cnt_nxt      = r_bit_cnt + 1'b1;
                    w_shift_nxt        = {r_shift[DATA_W-2:0], 1'b0};
                    w_serial_valid_nxt = 1'b1;
`ifdef SERIAL_SCHED_PARITY_EN
                    w_serial_out_nxt   = (r_bit_cnt == c_LAST_DATA) ? r_parity : r_shift[DATA_W-1];
`else
                    w_serial_out_nxt   = r_shift[DATA_W-1];
`endif
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= 4'd0;
            r_last_grant   <= 1'b1;
            r_gnt_0        <= 1'b0;
            r_gnt_1        <= 1'b0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_owner        <= 1'b0;
            r_busy         <= 1'b0;
`ifdef SERIAL_SCHED_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_shift        <= w_shift_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_last_grant   <= w_last_grant_nxt;
            r_gnt_0        <= w_gnt_0_nxt;
            r_gnt_1        <= w_gnt_1_nxt;
            r_serial_out   <= w_serial_out_nxt;
            r_serial_valid <= w_serial_valid_nxt;
            r_owner        <= w_owner_nxt;
            r_busy         <= w_busy_nxt;
`ifdef SERIAL_SCHED_PARITY_EN
            r_parity       <= w_parity_nxt;
`endif
        end
    end

    assign bus.gnt_0        = r_gnt_0;
    assign bus.gnt_1        = r_gnt_1;
    assign bus.serial_out   = r_serial_out;
    assign bus.serial_valid = r_serial_valid;
    assign bus.owner        = r_owner;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_out_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_out_scheduler
//  Description : Directed self-checking bench for serial_out_scheduler
//                (8-bit/gap-1 instance and 4-bit/gap-0 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_out_scheduler;

`ifdef SERIAL_SCHED_PARITY_EN
    localparam int c_FL_A = 9;
    localparam int c_FL_B = 5;
`else
    localparam int c_FL_A = 8;
    localparam int c_FL_B = 4;
`endif
    localparam int c_PERIOD_A = 1 + c_FL_A + 1;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    serial_out_scheduler_if #(.DATA_W(8)) ifa ();
    serial_out_scheduler_if #(.DATA_W(4)) ifb ();

    serial_out_scheduler #(.DATA_W(8), .GAP_CYCLES(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    serial_out_scheduler #(.DATA_W(4), .GAP_CYCLES(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        ifa.req_0 = 1'b0; ifa.req_1 = 1'b0; ifa.data_0 = '0; ifa.data_1 = '0;
        ifb.req_0 = 1'b0; ifb.req_1 = 1'b0; ifb.data_0 = '0; ifb.data_1 = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        checks++;
        if ({ifa.gnt_0, ifa.gnt_1, ifa.serial_out, ifa.serial_valid, ifa.owner, ifa.busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs_a: got %b want 000000",
                     {ifa.gnt_0, ifa.gnt_1, ifa.serial_out, ifa.serial_valid, ifa.owner, ifa.busy});
        end
        checks++;
        if ({ifb.gnt_0, ifb.gnt_1, ifb.serial_out, ifb.serial_valid, ifb.owner, ifb.busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs_b: got %b want 000000",
                     {ifb.gnt_0, ifb.gnt_1, ifb.serial_out, ifb.serial_valid, ifb.owner, ifb.busy});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (ifa.busy !== 1'b0 || ifa.serial_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b valid=%b want 0 0", ifa.busy, ifa.serial_valid);
        end
    endtask

    task automatic test_single;
        logic [8:0] pat;
        pat = 9'b1010_0101_0;
        do_reset();
        ifa.data_0 = 8'hA5;
        ifa.req_0  = 1'b1;
        tick();
        checks++;
        if (ifa.gnt_0 !== 1'b1 || ifa.gnt_1 !== 1'b0 || ifa.owner !== 1'b0 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt0=%b gnt1=%b owner=%b busy=%b want 1 0 0 1",
                     ifa.gnt_0, ifa.gnt_1, ifa.owner, ifa.busy);
        end
        ifa.req_0 = 1'b0;
        for (int b = 0; b < c_FL_A; b++) begin
            checks++;
            if (ifa.serial_valid !== 1'b1 || ifa.serial_out !== pat[8-b]) begin
                errors++;
                $display("FAIL single_bit%0d: valid=%b out=%b want 1 %b", b, ifa.serial_valid, ifa.serial_out, pat[8-b]);
            end
            if (b > 0) begin
                checks++;
                if (ifa.gnt_0 !== 1'b0) begin
                    errors++;
                    $display("FAIL single_gnt_pulse%0d: gnt0=%b want 0", b, ifa.gnt_0);
                end
            end
            tick();
        end
        checks++;
        if (ifa.serial_valid !== 1'b0 || ifa.serial_out !== 1'b0 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap: valid=%b out=%b busy=%b want 0 0 1", ifa.serial_valid, ifa.serial_out, ifa.busy);
        end
        tick();
        checks++;
        if (ifa.busy !== 1'b0 || ifa.serial_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b valid=%b want 0 0", ifa.busy, ifa.serial_valid);
        end
    endtask

    task automatic test_contention;
        int  n;
        bit  found;
        do_reset();
        ifa.data_0 = 8'h0F;
        ifa.data_1 = 8'hF0;
        ifa.req_0  = 1'b1;
        ifa.req_1  = 1'b1;
        tick();
        checks++;
        if (ifa.gnt_0 !== 1'b1 || ifa.gnt_1 !== 1'b0 || ifa.owner !== 1'b0 || ifa.serial_out !== 1'b0) begin
            errors++;
            $display("FAIL contention_first: gnt0=%b gnt1=%b owner=%b out=%b want 1 0 0 0",
                     ifa.gnt_0, ifa.gnt_1, ifa.owner, ifa.serial_out);
        end
        ifa.req_0 = 1'b0;
        n = 0;
        found = 1'b0;
        while (n < 30 && !found) begin
            tick();
            n++;
            if (ifa.gnt_1 === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || n != c_PERIOD_A) begin
            errors++;
            $display("FAIL contention_spacing: found=%0d cycles=%0d want 1 %0d", found, n, c_PERIOD_A);
        end
        checks++;
        if (ifa.owner !== 1'b1 || ifa.gnt_0 !== 1'b0 || ifa.serial_out !== 1'b1) begin
            errors++;
            $display("FAIL contention_second: owner=%b gnt0=%b out=%b want 1 0 1", ifa.owner, ifa.gnt_0, ifa.serial_out);
        end
        ifa.req_1 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int   ng;
        int   both;
        logic exp_src;
        do_reset();
        ng = 0;
        both = 0;
        exp_src = 1'b0;
        ifa.data_0 = 8'h3C;
        ifa.data_1 = 8'hC3;
        ifa.req_0 = 1'b1;
        ifa.req_1 = 1'b1;
        for (int c = 0; c < 200 && ng < 6; c++) begin
            tick();
            if (ifa.gnt_0 === 1'b1 && ifa.gnt_1 === 1'b1) both++;
            if (ifa.gnt_0 === 1'b1 || ifa.gnt_1 === 1'b1) begin
                checks++;
                if (ifa.gnt_1 !== exp_src) begin
                    errors++;
                    $display("FAIL alternate_grant%0d: gnt1=%b want %b", ng, ifa.gnt_1, exp_src);
                end
                exp_src = ~exp_src;
                ng++;
            end
            ifa.req_0 = ~ifa.gnt_0;
            ifa.req_1 = ~ifa.gnt_1;
        end
        checks++;
        if (ng != 6 || both != 0) begin
            errors++;
            $display("FAIL alternate_count: grants=%0d both_high=%0d want 6 0", ng, both);
        end
        ifa.req_0 = 1'b0;
        ifa.req_1 = 1'b0;
    endtask

    task automatic test_mid_frame;
        int   n;
        bit   found;
        logic pb;
        do_reset();
        ifa.data_0 = 8'h3C;
        ifa.req_0  = 1'b1;
        tick();
        checks++;
        if (ifa.gnt_0 !== 1'b1) begin
            errors++;
            $display("FAIL midframe_gnt0: got %b want 1", ifa.gnt_0);
        end
        ifa.req_0 = 1'b0;
        tick(); tick(); tick();
        ifa.data_1 = 8'h81;
        ifa.req_1  = 1'b1;
        n = 3;
        found = 1'b0;
        pb = 1'b1;
        while (n < 30 && !found) begin
            pb = ifa.busy;
            tick();
            n++;
            if (ifa.gnt_1 === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || n != c_PERIOD_A || pb !== 1'b0) begin
            errors++;
            $display("FAIL midframe_gnt1: found=%0d cycle=%0d prev_busy=%b want 1 %0d 0", found, n, pb, c_PERIOD_A);
        end
        checks++;
        if (ifa.owner !== 1'b1 || ifa.serial_out !== 1'b1) begin
            errors++;
            $display("FAIL midframe_owner: owner=%b out=%b want 1 1", ifa.owner, ifa.serial_out);
        end
        ifa.req_1 = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        do_reset();
        ifa.data_0 = 8'hFF;
        ifa.req_0  = 1'b1;
        tick();
        ifa.req_0 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (ifa.serial_valid !== 1'b1 || ifa.serial_out !== 1'b1 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: valid=%b out=%b busy=%b want 1 1 1", ifa.serial_valid, ifa.serial_out, ifa.busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ifa.gnt_0, ifa.gnt_1, ifa.serial_out, ifa.serial_valid, ifa.owner, ifa.busy} !== 6'b0) begin
            errors++;
            $display("FAIL abort_async: got %b want 000000",
                     {ifa.gnt_0, ifa.gnt_1, ifa.serial_out, ifa.serial_valid, ifa.owner, ifa.busy});
        end
        ifa.data_0 = 8'h12;
        ifa.data_1 = 8'h34;
        ifa.req_0  = 1'b1;
        ifa.req_1  = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (ifa.gnt_0 !== 1'b1 || ifa.gnt_1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_regrant: gnt0=%b gnt1=%b want 1 0", ifa.gnt_0, ifa.gnt_1);
        end
        ifa.req_0 = 1'b0;
        ifa.req_1 = 1'b0;
    endtask

    task automatic test_no_gap;
        logic [4:0] pat;
        pat = 5'b1001_0;
        do_reset();
        ifb.data_0 = 4'h9;
        ifb.req_0  = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (ifb.gnt_0 !== 1'b1) begin
                errors++;
                $display("FAIL nogap_gnt_f%0d: got %b want 1", f, ifb.gnt_0);
            end
            for (int b = 0; b < c_FL_B; b++) begin
                checks++;
                if (ifb.serial_valid !== 1'b1 || ifb.serial_out !== pat[4-b]) begin
                    errors++;
                    $display("FAIL nogap_f%0d_bit%0d: valid=%b out=%b want 1 %b",
                             f, b, ifb.serial_valid, ifb.serial_out, pat[4-b]);
                end
                tick();
            end
            checks++;
            if (ifb.serial_valid !== 1'b0 || ifb.busy !== 1'b0) begin
                errors++;
                $display("FAIL nogap_idle_f%0d: valid=%b busy=%b want 0 0", f, ifb.serial_valid, ifb.busy);
            end
            tick();
        end
        ifb.req_0 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_mid_frame();
        test_reset_mid_frame();
        test_no_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_out_scheduler.md
# serial_out_scheduler

Two-requester scheduler for the shared serial output buffer. Each requester presents a `DATA_W`-bit word with a request; the block arbitrates round-robin, captures the granted word and shifts it out MSB-first on a single serial line. It then inserts a programmable idle gap before re-arbitrating. It sits between the parallel producers and the serial pin, replacing ad-hoc per-producer serialisation.

## Interface
- `DATA_W`, 8, word width in bits (2..32)
- `GAP_CYCLES`, 1, idle cycles inserted after every frame (0..15)

- `clock`  in  1  single clock; all logic rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `data_0`  in  `DATA_W`  word from requester 0
- `data_1`  in  `DATA_W`  word from requester 1
- `req_0`  in  1  requester 0 has a word ready
- `req_1`  in  1  requester 1 has a word ready
- `gnt_0`  out  1  one-cycle pulse: `data_0` captured
- `gnt_1`  out  1  one-cycle pulse: `data_1` captured
- `serial_out`  out  1  serial data bit
- `serial_valid`  out  1  `serial_out` carries a frame bit this cycle
- `owner`  out  1  source of the current or last frame (0/1)
- `busy`  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: arbitrates.
  - SHIFT: drives the frame bits.
  - GAP: idle gap.
- IDLE:
  - With no request, remain in IDLE.
  - With any request sampled at edge k, go to SHIFT. In the cycle after edge k: pulse `gnt_N`, load the shift register with `data_N`, set `owner`=N, assert `serial_valid`, drive `serial_out`=`data_N[DATA_W-1]`.
- Arbitration:
  - Single requester: grant it.
  - Both requesting: grant the requester not granted last (`last_grant` register).
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- Requester handshake:
  - Hold `req_N` and `data_N` stable until `gnt_N` is seen.
  - Deassert `req_N` at the edge ending the `gnt_N` cycle.
  - A `req_N` still high on a later IDLE sample is a new request.
  - `data_N` is not sampled outside the grant edge.
- SHIFT:
  - Shift left one bit per cycle. `serial_valid` stays high for exactly FRAME_LEN cycles.
  - FRAME_LEN = `DATA_W` (+1 with parity, see Configuration).
  - Bit counter width is `$clog2(DATA_W+2)`. Compare it to FRAME_LEN-1 to exit SHIFT.
  - Requests arriving during SHIFT/GAP are ignored (not latched). They are served at the next IDLE sample if still asserted.
- GAP:
  - `serial_valid`=0, `serial_out`=0 for `GAP_CYCLES` cycles, then IDLE.
  - With `GAP_CYCLES`=0, go directly from SHIFT to IDLE.
- `gnt_0`/`gnt_1` are never high together and never high outside the first SHIFT cycle.
- Reset (any time, including mid-frame):
  - The frame is aborted, not resumed.
  - State IDLE; `gnt_0`, `gnt_1`, `serial_out`, `serial_valid`, `busy`, `owner` = 0; shift register and counters = 0; `last_grant`=1.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Request-to-grant latency: 1 cycle (grant in the cycle after the sampling edge). The first serial bit coincides with the grant.
- Frame period with continuous requests: 1 (IDLE) + FRAME_LEN + `GAP_CYCLES` cycles. Default: 10 cycles.
- `busy` rises with the grant and falls on entering IDLE.

## Configuration
- `SERIAL_SCHED_PARITY_EN` defined:
  - After the `DATA_W` data bits, one extra bit equal to even parity (XOR of the captured word) is sent with `serial_valid` high.
  - FRAME_LEN = `DATA_W`+1. Parity is computed from the captured register, not from live `data_N`.
- Not defined:
  - FRAME_LEN = `DATA_W`, no parity logic.
  - `serial_valid` drops immediately after the LSB.

## Test plan
- Reset, then only `req_0`=1 with `data_0`=8'hA5:
  - `gnt_0` pulses 1 cycle later.
  - `serial_out` = 1,0,1,0,0,1,0,1 over 8 `serial_valid` cycles, then 1 gap cycle, then IDLE.
  - With parity enabled, a 9th bit = 0.
- Simultaneous requests, `req_0`=`req_1`=1 held by a model that drops each on grant, `data_0`=8'h0F, `data_1`=8'hF0:
  - Grants ordered 0, 1.
  - `owner` 0 then 1.
  - Second frame starts 10 cycles after the first grant.
- Both requesters continuously re-requesting for 6 frames: grants strictly alternate 0,1,0,1,0,1. No cycle has both grants high.
- `req_1` raised mid-frame of a requester-0 transfer: no `gnt_1` until the frame and gap finish. `gnt_1` fires in the first cycle after the IDLE sample.
- `reset` asserted on the 4th shift cycle of `data_0`=8'hFF:
  - All outputs 0 asynchronously; `serial_valid` drops the same cycle.
  - After release with both requesting, requester 0 is granted first.
- `GAP_CYCLES`=0, `DATA_W`=4, `req_0` continuous with `data_0`=4'h9: `serial_valid` high 4 cycles, low 1 cycle (IDLE), repeating.
